// File: rtl/afu_intr_arbiter_if.sv
// AFU interrupt and PCIe MSI-X request signals between the interrupt arbiter and its neighbours.
// The slave modport is the arbiter's view; the master modport is the driving environment.
interface afu_intr_arbiter_if #(
    parameter int NUM_AFUS           = 1,
    parameter int NUM_AFU_INTERRUPTS = 7
);
    localparam int NVEC  = NUM_AFUS * NUM_AFU_INTERRUPTS;
    localparam int VEC_W = (NVEC > 1) ? $clog2(NVEC) : 1;
    localparam int ID_W  = (NUM_AFU_INTERRUPTS > 1) ? $clog2(NUM_AFU_INTERRUPTS) : 1;

    logic [NUM_AFUS-1:0]      afu_intr_valid;
    logic [NUM_AFUS*ID_W-1:0] afu_intr_id;
    logic [NUM_AFUS-1:0]      afu_intr_ack;
    logic [ID_W-1:0]          afu_intr_ack_id;
    logic [NUM_AFUS-1:0]      afu_intr_err;
    logic [NVEC-1:0]          vec_mask;
    logic                     msix_req_valid;
    logic [VEC_W-1:0]         msix_req_vec;
    logic                     msix_req_ready;
    logic                     msix_done;
    logic [NVEC-1:0]          pba;

    modport slave (
        input  afu_intr_valid, afu_intr_id, vec_mask, msix_req_ready, msix_done,
        output afu_intr_ack, afu_intr_ack_id, afu_intr_err, msix_req_valid, msix_req_vec, pba
    );

    modport master (
        output afu_intr_valid, afu_intr_id, vec_mask, msix_req_ready, msix_done,
        input  afu_intr_ack, afu_intr_ack_id, afu_intr_err, msix_req_valid, msix_req_vec, pba
    );
endinterface

// File: rtl/afu_intr_arbiter.sv
// Collects per-AFU MSI-X requests into a pending array and issues unmasked vectors
// round-robin onto a single MSI-X channel, one outstanding at a time.
module afu_intr_arbiter #(
    parameter int NUM_AFUS           = 1,
    parameter int NUM_AFU_INTERRUPTS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    afu_intr_arbiter_if.slave     bus
);
    localparam int NVEC  = NUM_AFUS * NUM_AFU_INTERRUPTS;
    localparam int VEC_W = (NVEC > 1) ? $clog2(NVEC) : 1;
    localparam int ID_W  = (NUM_AFU_INTERRUPTS > 1) ? $clog2(NUM_AFU_INTERRUPTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [NVEC-1:0]     r_pending, w_set, w_clr, w_elig;
    logic [VEC_W-1:0]    r_rr, w_rr_nxt, r_vec, w_vec_nxt, w_pick;
    logic                r_valid, w_valid_nxt, w_found;
    logic [NUM_AFUS-1:0] r_ack, w_ack_nxt, r_err, w_err_nxt;
    logic [ID_W-1:0]     r_ack_id, w_ack_id_nxt, w_id;
    int                  w_idx, w_afu, w_sub;

    // Decode incoming requests into pending-set bits and illegal-id error pulses.
    always_comb begin
        w_set     = {NVEC{1'b0}};
        w_err_nxt = {NUM_AFUS{1'b0}};
        w_id      = {ID_W{1'b0}};
        for (int i = 0; i < NUM_AFUS; i++) begin
            w_id = bus.afu_intr_id[i*ID_W +: ID_W];
            if (bus.afu_intr_valid[i]) begin
                if (32'(w_id) < NUM_AFU_INTERRUPTS) begin
                    w_set[VEC_W'(i * NUM_AFU_INTERRUPTS + int'(32'(w_id)))] = 1'b1;
                end else begin
                    w_err_nxt[i] = 1'b1;
                end
            end else begin
                w_err_nxt[i] = 1'b0;
            end
        end
    end

    // First eligible vector at or after the round-robin pointer, wrapping at NVEC.
    always_comb begin
        w_elig  = r_pending & ~bus.vec_mask;
        w_found = 1'b0;
        w_pick  = {VEC_W{1'b0}};
        w_idx   = 0;
        for (int k = 0; k < NVEC; k++) begin
            w_idx = (int'(r_rr) + k >= NVEC) ? (int'(r_rr) + k - NVEC) : (int'(r_rr) + k);
            if (!w_found && w_elig[VEC_W'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = VEC_W'(w_idx);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state and next-output logic for the single-outstanding request FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_vec_nxt    = r_vec;
        w_valid_nxt  = r_valid;
        w_rr_nxt     = r_rr;
        w_clr        = {NVEC{1'b0}};
        w_ack_nxt    = {NUM_AFUS{1'b0}};
        w_ack_id_nxt = r_ack_id;
        w_afu        = int'(r_vec) / NUM_AFU_INTERRUPTS;
        w_sub        = int'(r_vec) % NUM_AFU_INTERRUPTS;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_vec_nxt   = w_pick;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_valid_nxt = 1'b0;
                end
            end
            ST_REQ: begin
                // Mask is deliberately not re-checked once the request is presented.
                if (r_valid && bus.msix_req_ready) begin
                    w_clr[r_vec] = 1'b1;
                    w_rr_nxt     = (r_vec == VEC_W'(NVEC - 1)) ? {VEC_W{1'b0}} : (r_vec + VEC_W'(1));
                    w_valid_nxt  = 1'b0;
                    w_state_nxt  = ST_WAIT;
                end else begin
                    w_valid_nxt  = r_valid;
                end
            end
            ST_WAIT: begin
                if (bus.msix_done) begin
                    for (int a = 0; a < NUM_AFUS; a++) begin
                        w_ack_nxt[a] = (w_afu == a);
                    end
                    w_ack_id_nxt = ID_W'(w_sub);
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt  = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pending array and registered outputs; a set on the accept edge beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= {NVEC{1'b0}};
            r_rr      <= {VEC_W{1'b0}};
            r_vec     <= {VEC_W{1'b0}};
            r_valid   <= 1'b0;
            r_ack     <= {NUM_AFUS{1'b0}};
            r_ack_id  <= {ID_W{1'b0}};
            r_err     <= {NUM_AFUS{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_rr      <= w_rr_nxt;
            r_vec     <= w_vec_nxt;
            r_valid   <= w_valid_nxt;
            r_ack     <= w_ack_nxt;
            r_ack_id  <= w_ack_id_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign bus.msix_req_valid  = r_valid;
    assign bus.msix_req_vec    = r_vec;
    assign bus.afu_intr_ack    = r_ack;
    assign bus.afu_intr_ack_id = r_ack_id;
    assign bus.afu_intr_err    = r_err;
    assign bus.pba             = r_pending;

endmodule

// File: tb/tb_afu_intr_arbiter.sv
// Scoreboard bench for afu_intr_arbiter (2 AFUs x 7 vectors): directed scenarios then random traffic,
// checked each cycle against a vector-set reference model and queued error/ack expectations.
module tb_afu_intr_arbiter;
    localparam int NA = 2;
    localparam int NI = 7;
    localparam int NV = NA * NI;
    localparam int IW = 3;

    typedef struct {
        int            due;
        logic [NA-1:0] m;
        int            id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    afu_intr_arbiter_if #(.NUM_AFUS(NA), .NUM_AFU_INTERRUPTS(NI)) bus ();

    afu_intr_arbiter #(.NUM_AFUS(NA), .NUM_AFU_INTERRUPTS(NI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t err_q[$];
    exp_t ack_q[$];
    int   grant_log[$];

    // reference model state: pending set, rr pointer, phase (0 idle, 1 requesting, 2 waiting)
    logic [NV-1:0] m_pend;
    logic [NV-1:0] m_set;
    logic [NV-1:0] m_clr;
    int            m_rr;
    int            m_state;
    int            m_vec;
    int            m_pick;
    logic [NA-1:0] exp_err;
    logic [NA-1:0] exp_ack;
    int            exp_ack_id;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick_first(input logic [NV-1:0] el, input int rr);
        for (int k = 0; k < NV; k++) begin
            if (el[(rr + k) % NV]) return (rr + k) % NV;
        end
        return -1;
    endfunction

    // Monitor + model: compare DUT state after each edge, then advance the model to the next edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid",  int'(bus.msix_req_valid), 0);
            chk("rst_vec",    int'(bus.msix_req_vec), 0);
            chk("rst_pba",    int'(bus.pba), 0);
            chk("rst_ack",    int'(bus.afu_intr_ack), 0);
            chk("rst_ack_id", int'(bus.afu_intr_ack_id), 0);
            chk("rst_err",    int'(bus.afu_intr_err), 0);
            m_pend  = '0;
            m_rr    = 0;
            m_state = 0;
            m_vec   = 0;
            ack_q.delete();
        end else begin
            chk("pba", int'(bus.pba), int'(m_pend));
            chk("req_valid", int'(bus.msix_req_valid), int'(m_state == 1));
            if (m_state == 1) chk("req_vec", int'(bus.msix_req_vec), m_vec);

            exp_err = '0;
            while (err_q.size() > 0 && err_q[0].due <= cyc) begin
                if (err_q[0].due == cyc) exp_err = exp_err | err_q[0].m;
                void'(err_q.pop_front());
            end
            chk("err", int'(bus.afu_intr_err), int'(exp_err));

            exp_ack = '0;
            exp_ack_id = 0;
            while (ack_q.size() > 0 && ack_q[0].due <= cyc) begin
                if (ack_q[0].due == cyc) begin
                    exp_ack = ack_q[0].m;
                    exp_ack_id = ack_q[0].id;
                end
                void'(ack_q.pop_front());
            end
            chk("ack", int'(bus.afu_intr_ack), int'(exp_ack));
            if (exp_ack != '0) chk("ack_id", int'(bus.afu_intr_ack_id), exp_ack_id);

            m_set = '0;
            for (int a = 0; a < NA; a++) begin
                if (bus.afu_intr_valid[a] && int'(bus.afu_intr_id[a*IW +: IW]) < NI)
                    m_set[a*NI + int'(bus.afu_intr_id[a*IW +: IW])] = 1'b1;
            end
            m_clr = '0;
            case (m_state)
                0: begin
                    m_pick = pick_first(m_pend & ~bus.vec_mask, m_rr);
                    if (m_pick >= 0) begin
                        m_state = 1;
                        m_vec   = m_pick;
                    end
                end
                1: begin
                    if (bus.msix_req_ready) begin
                        m_clr[m_vec] = 1'b1;
                        m_rr    = (m_vec + 1) % NV;
                        m_state = 2;
                        grant_log.push_back(m_vec);
                    end
                end
                default: begin
                    if (bus.msix_done) begin
                        ack_q.push_back('{cyc + 1, NA'(1) << (m_vec / NI), m_vec % NI});
                        m_state = 0;
                    end
                end
            endcase
            m_pend = (m_pend & ~m_clr) | m_set;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_req(input logic [NA-1:0] v, input logic [NA*IW-1:0] ids);
        logic [NA-1:0] em;
        em = '0;
        bus.afu_intr_valid = v;
        bus.afu_intr_id    = ids;
        for (int a = 0; a < NA; a++) begin
            if (v[a] && int'(ids[a*IW +: IW]) >= NI) em[a] = 1'b1;
        end
        if (em != '0) err_q.push_back('{cyc + 1, em, 0});
    endtask

    task automatic issue(input logic [NA-1:0] v, input logic [NA*IW-1:0] ids);
        drive_req(v, ids);
        step(1);
        bus.afu_intr_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic chk_log(input string n, input int cnt, input int e [4]);
        chk({n, "_count"}, grant_log.size(), cnt);
        for (int i = 0; i < cnt && i < grant_log.size(); i++) chk({n, "_vec"}, grant_log[i], e[i]);
        grant_log.delete();
    endtask

    initial begin
        bus.afu_intr_valid = '0;
        bus.afu_intr_id    = '0;
        bus.vec_mask       = '0;
        bus.msix_req_ready = 1'b1;
        bus.msix_done      = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);

        // basic delivery: AFU1 id 3 -> vec 10
        grant_log.delete();
        issue(2'b10, {3'd3, 3'd0});
        step(1);
        chk("t1_valid", int'(bus.msix_req_valid), 1);
        chk("t1_vec", int'(bus.msix_req_vec), 10);
        step(4);
        chk("t1_pba", int'(bus.pba), 0);
        chk_log("t1", 1, '{10, 0, 0, 0});

        // simultaneous requests from rr=0, then verify pointer landed at 8
        do_reset();
        issue(2'b11, {3'd0, 3'd6});
        step(10);
        issue(2'b11, {3'd2, 3'd0});
        step(10);
        chk_log("t2", 4, '{6, 7, 9, 0});

        // back-pressure: ready held low for 5 cycles
        do_reset();
        bus.msix_req_ready = 1'b0;
        issue(2'b01, {3'd0, 3'd4});
        step(1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", int'(bus.msix_req_valid), 1);
            chk("t3_hold_vec", int'(bus.msix_req_vec), 4);
            chk("t3_hold_pba", int'(bus.pba), 16);
            step(1);
        end
        bus.msix_req_ready = 1'b1;
        chk("t3_pre_accept_pba", int'(bus.pba), 16);
        step(1);
        chk("t3_post_accept_pba", int'(bus.pba), 0);
        step(4);
        chk_log("t3", 1, '{4, 0, 0, 0});

        // masked vector stays pending, then issues once unmasked
        do_reset();
        bus.vec_mask = 14'd4;
        issue(2'b01, {3'd0, 3'd2});
        step(20);
        chk("t4_masked_pba", int'(bus.pba), 4);
        chk("t4_masked_valid", int'(bus.msix_req_valid), 0);
        bus.vec_mask = '0;
        step(6);
        chk_log("t4", 1, '{2, 0, 0, 0});

        // illegal id, then a re-request landing on the accept edge
        issue(2'b01, {3'd0, 3'd7});
        step(1);
        chk("t5_illegal_pba", int'(bus.pba), 0);
        bus.msix_req_ready = 1'b0;
        issue(2'b01, {3'd0, 3'd5});
        step(2);
        bus.msix_req_ready = 1'b1;
        issue(2'b01, {3'd0, 3'd5});
        chk("t5_set_wins_pba", int'(bus.pba), 32);
        step(8);
        chk_log("t5", 2, '{5, 5, 0, 0});

        // reset while waiting for done abandons the request; rr wraps after vec 13
        bus.msix_done = 1'b0;
        issue(2'b10, {3'd1, 3'd0});
        step(4);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", int'(bus.msix_req_valid), 0);
        chk("t6_rst_pba", int'(bus.pba), 0);
        bus.msix_done = 1'b1;
        step(2);
        rst = 1'b0;
        grant_log.delete();
        step(3);
        issue(2'b10, {3'd6, 3'd0});
        step(6);
        issue(2'b11, {3'd5, 3'd0});
        step(10);
        chk_log("t6", 3, '{13, 0, 12, 0});

        // randomized traffic with random mask, ready and done
        for (int c = 0; c < 3000; c++) begin
            logic [IW-1:0] i0, i1;
            logic [NA-1:0] v;
            v[0] = ($urandom_range(0, 3) == 0);
            v[1] = ($urandom_range(0, 3) == 0);
            i0 = IW'($urandom_range(0, 7));
            i1 = IW'($urandom_range(0, 7));
            bus.msix_req_ready = ($urandom_range(0, 9) < 7);
            bus.msix_done      = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 49) == 0)
                bus.vec_mask = NV'($urandom) & NV'($urandom);
            drive_req(v, {i1, i0});
            step(1);
        end
        bus.afu_intr_valid = '0;
        bus.vec_mask       = '0;
        bus.msix_req_ready = 1'b1;
        bus.msix_done      = 1'b1;
        step(80);
        chk("drain_pba", int'(bus.pba), 0);
        chk("drain_err_q", err_q.size(), 0);
        chk("drain_ack_q", ack_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
